if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/mips_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 63 ++++++
 rtl/if_stage.sv | 103 ++++++++++
 tb/tb_if_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared constants and fetch-state encoding for the MIPS front end.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

   localparam logic [31:0] NOP               = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   // Sequential fetch address; wraps modulo 2^32 by construction.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register with bubble, hold and load controls.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bubble_i,
   input  logic        hold_i,
   input  logic        load_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc4_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc4_o,
   output logic        valid_o
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q,   pc4_d;
   logic        valid_q, valid_d;

   // Bubble wins over hold, hold wins over load; with no control asserted the contents stay put.
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (bubble_i) begin
         instr_d = NOP;
         pc4_d   = 32'h0000_0000;
         valid_d = 1'b0;
      end else if (hold_i) begin
         instr_d = instr_q;
         pc4_d   = pc4_q;
         valid_d = valid_q;
      end else if (load_i) begin
         instr_d = instr_i;
         pc4_d   = pc4_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= NOP;
         pc4_q   <= 32'h0000_0000;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign instr_o = instr_q;
   assign pc4_o   = pc4_q;
   assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction fetch stage: PC, BOOT/RUN/HALT control, IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        halted,
   output logic [31:0] fetch_count
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q,    pc_d;
   logic [31:0]  count_q, count_d;
   logic         ifid_bubble;
   logic         ifid_hold;
   logic         ifid_load;
   logic [31:0]  pc_next_seq;

   assign pc_next_seq = pc_plus4(pc_q);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      count_d     = count_q;
      ifid_bubble = 1'b0;
      ifid_hold   = 1'b0;
      ifid_load   = 1'b0;
      case (state_q)
         BOOT: begin
            state_d     = RUN;
            ifid_bubble = 1'b1;
         end
         RUN: begin
            // A resolved branch overrides any hazard stall in the same cycle.
            if (redirect) begin
               pc_d        = redirect_target;
               ifid_bubble = 1'b1;
            end else if (stall) begin
               ifid_hold   = 1'b1;
            end else if (imem_rdata == HALT_WORD) begin
               state_d     = HALT;
               ifid_bubble = 1'b1;
            end else begin
               pc_d        = pc_next_seq;
               ifid_load   = 1'b1;
               count_d     = count_q + 32'd1;
            end
         end
         default: begin
            ifid_bubble = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         count_q <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
      end
   end

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .rst_n    (reset),
      .bubble_i (ifid_bubble),
      .hold_i   (ifid_hold),
      .load_i   (ifid_load),
      .instr_i  (imem_rdata),
      .pc4_i    (pc_next_seq),
      .instr_o  (if_id_instr),
      .pc4_o    (if_id_pc4),
      .valid_o  (if_id_valid)
   );

   assign pc          = pc_q;
   assign imem_addr   = pc_q;
   assign halted      = (state_q == HALT);
   assign fetch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage against a rule-level fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

   localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;
   logic [31:0] fetch_count;

   logic        w_reset;
   logic        w_stall;
   logic        w_redirect;
   logic [31:0] w_target;
   logic [31:0] w_imem_addr;
   logic [31:0] w_imem_rdata;
   logic [31:0] w_pc;
   logic [31:0] w_instr;
   logic [31:0] w_pc4;
   logic        w_valid;
   logic        w_halted;
   logic [31:0] w_count;

   logic [31:0] mem [256];

   int tests;
   int fails;

   // Reference model: architectural view of the fetch stage.
   logic        m_started;
   logic        m_halt;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_valid;
   logic [31:0] m_count;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_rdata   = mem[imem_addr[9:2]];
   assign w_imem_rdata = 32'h1234_5678;

   if_stage dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .pc              (pc),
      .if_id_instr     (if_id_instr),
      .if_id_pc4       (if_id_pc4),
      .if_id_valid     (if_id_valid),
      .halted          (halted),
      .fetch_count     (fetch_count)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFFC), .HALT_WORD(32'hFFFF_FFFF)) dut_wrap (
      .clk             (clk),
      .reset           (w_reset),
      .stall           (w_stall),
      .redirect        (w_redirect),
      .redirect_target (w_target),
      .imem_addr       (w_imem_addr),
      .imem_rdata      (w_imem_rdata),
      .pc              (w_pc),
      .if_id_instr     (w_instr),
      .if_id_pc4       (w_pc4),
      .if_id_valid     (w_valid),
      .halted          (w_halted),
      .fetch_count     (w_count)
   );

   task automatic model_reset();
      m_started = 1'b0;
      m_halt    = 1'b0;
      m_pc      = 32'h0000_0000;
      m_instr   = 32'h0000_0000;
      m_pc4     = 32'h0000_0000;
      m_valid   = 1'b0;
      m_count   = 32'h0000_0000;
   endtask

   task automatic model_bubble();
      m_instr = 32'h0000_0000;
      m_pc4   = 32'h0000_0000;
      m_valid = 1'b0;
   endtask

   // Drive one cycle of inputs, advance the model, and land 1 ns after the edge.
   task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
      logic [31:0] word;
      stall           = st;
      redirect        = rd;
      redirect_target = tgt;
      if (!m_started) begin
         m_started = 1'b1;
         model_bubble();
      end else if (m_halt) begin
         model_bubble();
      end else if (rd) begin
         m_pc = tgt;
         model_bubble();
      end else if (!st) begin
         word = mem[m_pc[9:2]];
         if (word == HALT_W) begin
            m_halt = 1'b1;
            model_bubble();
         end else begin
            m_instr = word;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_count = m_count + 32'd1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      stall    = 1'b0;
      redirect = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      reset = 1'b1;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom;
         if (mem[i] == HALT_W) mem[i] = 32'h0000_0001;
      end
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      stall    = 1'b1;
      redirect = 1'b1;
      redirect_target = 32'h0000_0080;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({pc, imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count} !==
          {32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
         fails++;
         $display("FAIL reset_state: got pc=%h addr=%h instr=%h pc4=%h v=%b h=%b cnt=%0d, expected all zero",
                  pc, imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count);
      end
      model_reset();
      reset = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] exp_instr;
      do_reset();
      mem[0] = 32'h2008_0005;
      mem[1] = 32'h2009_0003;
      step(1'b0, 1'b0, 32'h0);
      tests++;
      if (if_id_valid !== 1'b0 || pc !== 32'h0) begin
         fails++;
         $display("FAIL boot_edge: got valid=%b pc=%h, expected valid=0 pc=0", if_id_valid, pc);
      end
      step(1'b0, 1'b0, 32'h0);
      tests++;
      if ({if_id_instr, if_id_pc4, if_id_valid, pc} !== {32'h2008_0005, 32'h4, 1'b1, 32'h4}) begin
         fails++;
         $display("FAIL first_fetch: got instr=%h pc4=%h v=%b pc=%h, expected 20080005/4/1/4",
                  if_id_instr, if_id_pc4, if_id_valid, pc);
      end
      step(1'b0, 1'b0, 32'h0);
      tests++;
      if ({if_id_instr, if_id_pc4, fetch_count, pc} !== {32'h2009_0003, 32'h8, 32'd2, 32'h8}) begin
         fails++;
         $display("FAIL second_fetch: got instr=%h pc4=%h cnt=%0d pc=%h, expected 20090003/8/2/8",
                  if_id_instr, if_id_pc4, fetch_count, pc);
      end
      for (int c = 0; c < 2; c++) begin
         step(1'b1, 1'b0, 32'h0);
         tests++;
         if ({pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count} !==
             {32'h8, 32'h2009_0003, 32'h8, 1'b1, 32'd2}) begin
            fails++;
            $display("FAIL stall_hold[%0d]: got pc=%h instr=%h pc4=%h v=%b cnt=%0d, expected 8/20090003/8/1/2",
                     c, pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count);
         end
      end
      exp_instr = mem[2];
      step(1'b0, 1'b0, 32'h0);
      tests++;
      if ({pc, if_id_instr, if_id_pc4, fetch_count} !== {32'hC, exp_instr, 32'hC, 32'd3}) begin
         fails++;
         $display("FAIL stall_resume: got pc=%h instr=%h pc4=%h cnt=%0d, expected C/%h/C/3",
                  pc, if_id_instr, if_id_pc4, fetch_count, exp_instr);
      end
      step(1'b1, 1'b1, 32'h40);
      tests++;
      if ({pc, if_id_valid, if_id_instr, if_id_pc4, fetch_count} !== {32'h40, 1'b0, 32'h0, 32'h0, 32'd3}) begin
         fails++;
         $display("FAIL redirect_over_stall: got pc=%h v=%b instr=%h pc4=%h cnt=%0d, expected 40/0/0/0/3",
                  pc, if_id_valid, if_id_instr, if_id_pc4, fetch_count);
      end
      exp_instr = mem[16];
      step(1'b0, 1'b0, 32'h0);
      tests++;
      if ({pc, if_id_instr, if_id_pc4, if_id_valid} !== {32'h44, exp_instr, 32'h44, 1'b1}) begin
         fails++;
         $display("FAIL fetch_after_redirect: got pc=%h instr=%h pc4=%h v=%b, expected 44/%h/44/1",
                  pc, if_id_instr, if_id_pc4, if_id_valid, exp_instr);
      end
   endtask

   task automatic test_random();
      logic        st;
      logic        rd;
      logic [31:0] tgt;
      do_reset();
      for (int c = 0; c < 300; c++) begin
         st  = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 9) == 0);
         tgt = {22'h0, 8'($urandom), 2'($urandom_range(0, 3) == 0 ? $urandom : 0)};
         step(st, rd, tgt);
         tests++;
         if ({pc, imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count} !==
             {m_pc, m_pc, m_instr, m_pc4, m_valid, m_halt, m_count}) begin
            fails++;
            $display("FAIL random[%0d]: got pc=%h addr=%h instr=%h pc4=%h v=%b h=%b cnt=%0d, expected pc=%h instr=%h pc4=%h v=%b h=%b cnt=%0d",
                     c, pc, imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count,
                     m_pc, m_instr, m_pc4, m_valid, m_halt, m_count);
         end
      end
   endtask

   task automatic test_halt();
      logic [31:0] saved;
      saved  = mem[4];
      mem[4] = HALT_W;
      do_reset();
      step(1'b0, 1'b0, 32'h0);
      for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 32'h0);
      tests++;
      if ({halted, pc, if_id_valid, fetch_count} !== {1'b1, 32'h10, 1'b0, 32'd4}) begin
         fails++;
         $display("FAIL halt_entry: got h=%b pc=%h v=%b cnt=%0d, expected 1/10/0/4",
                  halted, pc, if_id_valid, fetch_count);
      end
      for (int c = 0; c < 6; c++) begin
         step(1'($urandom), 1'b1, 32'h0);
         tests++;
         if ({halted, pc, if_id_valid, if_id_instr, fetch_count} !== {1'b1, 32'h10, 1'b0, 32'h0, 32'd4}) begin
            fails++;
            $display("FAIL halt_sticky[%0d]: got h=%b pc=%h v=%b instr=%h cnt=%0d, expected 1/10/0/0/4",
                     c, halted, pc, if_id_valid, if_id_instr, fetch_count);
         end
      end
      #2;
      reset = 1'b0;
      #1;
      tests++;
      if ({halted, pc, fetch_count} !== {1'b0, 32'h0, 32'h0}) begin
         fails++;
         $display("FAIL halt_reset: got h=%b pc=%h cnt=%0d, expected 0/0/0", halted, pc, fetch_count);
      end
      mem[4] = saved;
      do_reset();
   endtask

   task automatic test_async_reset();
      do_reset();
      step(1'b0, 1'b0, 32'h0);
      for (int c = 0; c < 9; c++) step(1'b0, 1'b0, 32'h0);
      tests++;
      if (pc !== 32'h24 || fetch_count !== 32'd9) begin
         fails++;
         $display("FAIL pre_reset_pc: got pc=%h cnt=%0d, expected 24/9", pc, fetch_count);
      end
      #3;
      reset = 1'b0;
      #1;
      tests++;
      if ({pc, if_id_valid, if_id_instr, if_id_pc4, fetch_count, halted} !==
          {32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
         fails++;
         $display("FAIL async_reset: got pc=%h v=%b instr=%h pc4=%h cnt=%0d h=%b, expected all zero before edge",
                  pc, if_id_valid, if_id_instr, if_id_pc4, fetch_count, halted);
      end
      do_reset();
   endtask

   task automatic test_pc_wrap();
      w_reset = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if ({w_pc, w_imem_addr, w_valid} !== {32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0}) begin
         fails++;
         $display("FAIL wrap_boot: got pc=%h addr=%h v=%b, expected FFFFFFFC/FFFFFFFC/0", w_pc, w_imem_addr, w_valid);
      end
      @(posedge clk);
      #1;
      tests++;
      if ({w_pc, w_pc4, w_instr, w_valid, w_count, w_halted} !==
          {32'h0, 32'h0, 32'h1234_5678, 1'b1, 32'd1, 1'b0}) begin
         fails++;
         $display("FAIL wrap_fetch: got pc=%h pc4=%h instr=%h v=%b cnt=%0d h=%b, expected 0/0/12345678/1/1/0",
                  w_pc, w_pc4, w_instr, w_valid, w_count, w_halted);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tests      = 0;
      fails      = 0;
      reset      = 1'b0;
      stall      = 1'b0;
      redirect   = 1'b0;
      redirect_target = 32'h0;
      w_reset    = 1'b0;
      w_stall    = 1'b0;
      w_redirect = 1'b0;
      w_target   = 32'h0;
      model_reset();
      fill_mem();
      @(posedge clk);
      #1;
      test_reset();
      test_directed();
      test_random();
      test_halt();
      test_async_reset();
      test_pc_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
